// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types and constants for the instruction fetch stage
// Contents: default reset PC, redirect control bundle, queue entry, fetch FSM states.
package fetch_stage_pkg;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
   } control_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        filled;
   } fetch_entry_t;
   typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch stage bus bundle (imem request/response, redirect, decode output)
// master: fetch stage side (drives imem_req_*, out_*); slave: memory/execute/decode side.
interface fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;
   logic        out_fault;
   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instruction, out_fault,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instruction, out_fault,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of fetch entries with alloc/fill/pop/flush
// Ports: i_alloc/i_alloc_pc reserve an entry, i_fill/i_fill_data complete the oldest
// unfilled entry, i_pop retires the head, i_flush clears all; o_head, o_count, o_unfilled.
module fetch_queue
   import fetch_stage_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_alloc,
   input  logic [31:0]   i_alloc_pc,
   input  logic          i_fill,
   input  logic [31:0]   i_fill_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output fetch_entry_t  o_head,
   output logic [CW-1:0] o_count,
   output logic [CW-1:0] o_unfilled
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t  r_q [DEPTH];
   logic [AW-1:0] r_head, r_tail, r_fptr;
   logic [CW-1:0] r_count, r_unfilled;
   // alloc, fill and pop always target distinct slots: fill needs an unfilled entry,
   // pop needs a filled head, alloc needs a free slot
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_fptr     <= '0;
         r_count    <= '0;
         r_unfilled <= '0;
         for (int k = 0; k < DEPTH; k++) r_q[k].filled <= 1'b0;
      end else begin
         if (i_alloc) begin
            r_q[r_tail] <= '{pc: i_alloc_pc, instr: '0, filled: 1'b0};
            r_tail      <= r_tail + AW'(1);
         end
         if (i_fill) begin
            r_q[r_fptr].instr  <= i_fill_data;
            r_q[r_fptr].filled <= 1'b1;
            r_fptr             <= r_fptr + AW'(1);
         end
         if (i_pop) begin
            r_q[r_head].filled <= 1'b0;
            r_head             <= r_head + AW'(1);
         end
         r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
         r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
      end
   end
   assign o_head     = r_q[r_head];
   assign o_count    = r_count;
   assign o_unfilled = r_unfilled;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: sequential-PC instruction fetch with pipelined imem requests and redirect flush
// Ports: clk, reset (sync, active-high); bus (fetch_stage_if.master) carrying imem request/
// response, redirect from execute and the instruction/PC/fault output to decode.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input logic           clk,
   input logic           reset,
   fetch_stage_if.master bus
);
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DMAX = CW'(DEPTH);
   fetch_state_t  r_state, w_state_nx;
   logic [31:0]   r_pc, r_fault_pc;
   logic [CW-1:0] r_discard, w_count, w_unfilled, w_outstanding;
   fetch_entry_t  w_head;
   control_t      w_redir;
   logic          w_req, w_accept, w_resp, w_drop, w_fill, w_pop;
   assign w_redir       = '{valid: bus.redirect_valid, pc: bus.redirect_pc};
   // every request still owed a response: live unfilled entries plus stale ones
   assign w_outstanding = w_unfilled + r_discard;
   assign w_resp        = bus.imem_resp_valid && w_outstanding != '0;
   assign w_drop        = w_resp && r_discard != '0;
   assign w_fill        = w_resp && r_discard == '0 && !w_redir.valid;
   assign w_req         = !reset && r_state == RUN && !w_redir.valid && w_count < DMAX && w_outstanding < DMAX;
   assign w_accept      = w_req && bus.imem_req_ready;
   assign w_pop         = bus.out_valid && bus.out_ready && r_state == RUN && !w_redir.valid;
   assign bus.imem_req_valid = w_req;
   assign bus.imem_req_addr  = r_pc;
   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .i_alloc    (w_accept),
      .i_alloc_pc (r_pc),
      .i_fill     (w_fill),
      .i_fill_data(bus.imem_resp_data),
      .i_pop      (w_pop),
      .i_flush    (w_redir.valid),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_unfilled (w_unfilled)
   );
   always_comb begin
      w_state_nx          = w_redir.valid ? (|w_redir.pc[1:0] ? FAULT : RUN) : r_state;
      bus.out_fault       = !reset && r_state == FAULT;
      bus.out_valid       = !reset && (r_state == FAULT || w_head.filled);
      bus.out_pc          = r_state == FAULT ? r_fault_pc : w_head.pc;
      bus.out_instruction = r_state == FAULT ? '0 : w_head.instr;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RUN;
         r_pc       <= RESET_PC;
         r_fault_pc <= RESET_PC;
         r_discard  <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_redir.valid) begin
            r_pc       <= w_redir.pc;
            r_fault_pc <= w_redir.pc;
            // all pre-redirect requests become stale, minus the one answered this cycle
            r_discard  <= w_outstanding - CW'(w_resp);
         end else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            r_discard <= r_discard - CW'(w_drop);
         end
      end
   end
   a_resp_outstanding: assert property (@(posedge clk) disable iff (reset)
      bus.imem_resp_valid |-> w_outstanding != '0);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a transaction-level model
module tb_fetch_stage;
   localparam int   DEPTH = 2;
   localparam logic H     = 1'b1;
   localparam logic L     = 1'b0;
   localparam logic [31:0] Z = 32'h0;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   fetch_stage_if bus();
   fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   task automatic drive(input logic rdy, resp, input logic [31:0] data, input logic redir,
                        input logic [31:0] rpc, input logic ordy);
      bus.imem_req_ready  = rdy;
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = data;
      bus.redirect_valid  = redir;
      bus.redirect_pc     = rpc;
      bus.out_ready       = ordy;
   endtask
   typedef struct {
      logic        rdy, resp;
      logic [31:0] data;
      logic        redir;
      logic [31:0] rpc;
      logic        ordy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_pc, e_instr;
      logic        e_flt;
   } vec_t;
   vec_t tbl [15];
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; logic filled; } ment_t;
   mreq_t pipe [$];
   ment_t live [$];
   initial begin
      logic        rst, rdy, resp, redir, ordy, e_req, e_ov, m_fault;
      logic [31:0] rpc, rdata, m_req, m_fpc, exp_next, t;
      int          stale, last_due, stall, osz, due;
      drive(L, L, Z, L, Z, L);
      tbl[0]  = '{H, L, Z, L, Z, H, H, 32'h0, L, Z, Z, L};
      tbl[1]  = '{H, L, Z, L, Z, H, H, 32'h4, L, Z, Z, L};
      tbl[2]  = '{H, H, memfn(32'h0), L, Z, H, L, Z, L, Z, Z, L};
      tbl[3]  = '{H, H, memfn(32'h4), L, Z, H, L, Z, H, 32'h0, memfn(32'h0), L};
      tbl[4]  = '{H, L, Z, L, Z, H, H, 32'h8, H, 32'h4, memfn(32'h4), L};
      tbl[5]  = '{L, L, Z, L, Z, H, H, 32'hC, L, Z, Z, L};
      tbl[6]  = '{H, H, memfn(32'h8), H, 32'h100, H, L, Z, L, Z, Z, L};
      tbl[7]  = '{H, L, Z, L, Z, L, H, 32'h100, L, Z, Z, L};
      tbl[8]  = '{H, L, Z, L, Z, L, H, 32'h104, L, Z, Z, L};
      tbl[9]  = '{H, H, memfn(32'h100), L, Z, L, L, Z, L, Z, Z, L};
      tbl[10] = '{H, L, Z, H, 32'h102, L, L, Z, H, 32'h100, memfn(32'h100), L};
      tbl[11] = '{H, H, memfn(32'h104), L, Z, H, L, Z, H, 32'h102, Z, H};
      tbl[12] = '{H, L, Z, L, Z, H, L, Z, H, 32'h102, Z, H};
      tbl[13] = '{H, L, Z, H, 32'h200, H, L, Z, H, 32'h102, Z, H};
      tbl[14] = '{H, L, Z, L, Z, H, H, 32'h200, L, Z, Z, L};
      repeat (2) @(negedge clk);
      #1;
      chk("reset req_valid", bus.imem_req_valid, 0);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset out_fault", bus.out_fault, 0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         reset = 1'b0;
         drive(tbl[i].rdy, tbl[i].resp, tbl[i].data, tbl[i].redir, tbl[i].rpc, tbl[i].ordy);
         #1;
         chk($sformatf("v%0d req_valid", i), bus.imem_req_valid, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("v%0d req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
         chk($sformatf("v%0d out_valid", i), bus.out_valid, tbl[i].e_ov);
         chk($sformatf("v%0d out_fault", i), bus.out_fault, tbl[i].e_flt);
         if (tbl[i].e_ov) begin
            chk($sformatf("v%0d out_pc", i), bus.out_pc, tbl[i].e_pc);
            chk($sformatf("v%0d out_instr", i), bus.out_instruction, tbl[i].e_instr);
         end
      end
      // reset with two requests outstanding
      @(negedge clk);
      drive(H, L, Z, L, Z, H);
      #1;
      chk("mid req_valid", bus.imem_req_valid, 1);
      chk("mid req_addr", bus.imem_req_addr, 32'h204);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid reset req_valid", bus.imem_req_valid, 0);
      chk("mid reset out_valid", bus.out_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post reset out_valid", bus.out_valid, 0);
      chk("post reset req_valid", bus.imem_req_valid, 1);
      chk("post reset req_addr", bus.imem_req_addr, 32'h0);
      // randomized run against the transaction model
      stall = 0;
      last_due = -1;
      stale = 0;
      m_fault = 1'b0;
      m_req = 32'h0;
      m_fpc = 32'h0;
      exp_next = 32'h0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         rst = cyc < 2 || $urandom_range(0, 499) == 0;
         rdy = $urandom_range(0, 3) != 0;
         if (stall == 0 && $urandom_range(0, 19) == 0) stall = $urandom_range(3, 12);
         ordy = stall == 0 && $urandom_range(0, 3) != 0;
         if (stall > 0) stall--;
         redir = !rst && (m_fault ? $urandom_range(0, 3) == 0 : $urandom_range(0, 29) == 0);
         t = $urandom;
         rpc = {20'h0, t[11:2], 2'b00};
         if ($urandom_range(0, 4) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         osz = pipe.size();
         resp = !rst && osz > 0 && pipe[0].due <= cyc;
         rdata = 32'h0;
         if (resp) begin
            rdata = memfn(pipe[0].addr);
            void'(pipe.pop_front());
         end
         reset = rst;
         drive(rdy, resp, rdata, redir, rpc, ordy);
         #1;
         e_req = !rst && !m_fault && !redir && live.size() < DEPTH && osz < DEPTH;
         e_ov  = !rst && (m_fault || (live.size() > 0 && live[0].filled));
         chk("rnd req_valid", bus.imem_req_valid, e_req);
         if (e_req) chk("rnd req_addr", bus.imem_req_addr, m_req);
         chk("rnd out_valid", bus.out_valid, e_ov);
         chk("rnd out_fault", bus.out_fault, !rst && m_fault);
         if (e_ov && m_fault) begin
            chk("rnd fault pc", bus.out_pc, m_fpc);
            chk("rnd fault instr", bus.out_instruction, 0);
         end else if (e_ov) begin
            chk("rnd out_pc", bus.out_pc, live[0].pc);
            chk("rnd out_instr", bus.out_instruction, live[0].instr);
         end
         if (!rst && bus.imem_req_valid && rdy) begin
            due = cyc + int'($urandom_range(1, 3));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pipe.push_back('{addr: bus.imem_req_addr, due: due});
         end
         if (rst) begin
            live.delete();
            pipe.delete();
            stale = 0;
            m_fault = 1'b0;
            m_req = 32'h0;
            exp_next = 32'h0;
         end else if (redir) begin
            live.delete();
            stale = pipe.size();
            m_fault = |rpc[1:0];
            m_fpc = rpc;
            m_req = rpc;
            exp_next = rpc;
         end else begin
            if (e_ov && ordy && !m_fault) begin
               chk("stream pc", bus.out_pc, exp_next);
               chk("stream instr", bus.out_instruction, memfn(exp_next));
               exp_next += 32'd4;
               void'(live.pop_front());
            end
            if (resp && stale > 0) stale--;
            else if (resp) begin
               for (int j = 0; j < live.size(); j++)
                  if (!live[j].filled) begin
                     live[j].instr = rdata;
                     live[j].filled = 1'b1;
                     break;
                  end
            end
            if (e_req && rdy) begin
               live.push_back('{pc: m_req, instr: 32'h0, filled: 1'b0});
               m_req += 32'd4;
            end
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
